// File: rtl/alu_sequencer.sv
`timescale 1ns/1ps
// alu_sequencer
//
// Multi-cycle controller between the instruction decoder and the 6502 ALU
// datapath. One arithmetic/logic request is accepted per handshake, mapped
// onto one ALU pass (two with decimal correction), and the result byte plus
// the updated status byte are returned on a valid/ready response channel.
// The N/V/Z/C flags are derived here from the operands and the ALU outputs.
//
// Optional feature: define DECIMAL_EN to enable BCD correction for ADC/SBC
// when the D flag (status bit 3) is set. Without it the D flag is ignored
// and every op is a single binary pass.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_op[3:0]                 0 ADC 1 SBC 2 AND 3 ORA 4 EOR 5 ASL 6 LSR
//                               7 ROL 8 ROR 9 CMP 10 INC 11 DEC 12 BIT,
//                               13..15 illegal
//   req_a, req_b, req_p [7:0]   operands and current status byte
//   alu_ctrl[2:0]               0 SUM 1 OR 2 XOR 3 AND 4 SR
//   alu_AI, alu_BI [7:0]        ALU operands
//   alu_carry, alu_DAA          ALU carry in; DAA tied low
//   alu_Y[7:0], alu_flags[7:0]  ALU result; flags[0] is carry out
//   rsp_valid/rsp_ready         response handshake
//   rsp_y, rsp_p [7:0]          result byte, updated status byte
//   rsp_wr                      result must be written back

module alu_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic [7:0] req_p,
    output logic [2:0] alu_ctrl,
    output logic [7:0] alu_AI,
    output logic [7:0] alu_BI,
    output logic       alu_carry,
    output logic       alu_DAA,
    input  logic [7:0] alu_Y,
    input  logic [7:0] alu_flags,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_y,
    output logic [7:0] rsp_p,
    output logic       rsp_wr
);

    localparam logic [3:0] OP_ADC = 4'd0;
    localparam logic [3:0] OP_SBC = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_ORA = 4'd3;
    localparam logic [3:0] OP_EOR = 4'd4;
    localparam logic [3:0] OP_ASL = 4'd5;
    localparam logic [3:0] OP_LSR = 4'd6;
    localparam logic [3:0] OP_ROL = 4'd7;
    localparam logic [3:0] OP_ROR = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;
    localparam logic [3:0] OP_INC = 4'd10;
    localparam logic [3:0] OP_DEC = 4'd11;
    localparam logic [3:0] OP_BIT = 4'd12;

    localparam logic [2:0] CTRL_SUM = 3'd0;
    localparam logic [2:0] CTRL_OR  = 3'd1;
    localparam logic [2:0] CTRL_XOR = 3'd2;
    localparam logic [2:0] CTRL_AND = 3'd3;
    localparam logic [2:0] CTRL_SR  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
`ifdef DECIMAL_EN
        S_ADJ  = 2'd3,
`endif
        S_RESP = 2'd2
    } state_t;

    state_t     state_reg, state_next;

    // Request captured at accept
    logic [3:0] op_reg;
    logic [7:0] a_reg;
    logic [7:0] b_reg;
    logic [7:0] p_reg;

    // Response registers, held stable through RESP
    logic [7:0] rsp_y_reg;
    logic [7:0] rsp_p_reg;
    logic       rsp_wr_reg;

    // EXEC-pass result as seen by the response path
    logic [7:0] exec_y;
    logic [7:0] exec_p;
    logic       exec_wr;

    // Only carry out is consumed from the ALU flag byte
    logic       unused_flags;
    assign unused_flags = &{1'b0, alu_flags[7:1]};

`ifdef DECIMAL_EN
    // Binary pass results kept for the correction pass
    logic [7:0] bin_y_reg;
    logic       bin_c_reg;
    logic       hc_reg;
    logic       dec_run;
    logic [4:0] low_sum;
    logic [7:0] adj_corr;
    logic       adj_c;

    assign dec_run = p_reg[3] && ((op_reg == OP_ADC) || (op_reg == OP_SBC));
    // Half carry of the binary pass, using the operands actually fed to the ALU
    assign low_sum = {1'b0, a_reg[3:0]} + {1'b0, alu_BI[3:0]} + {4'd0, alu_carry};

    always_comb begin
        adj_corr = 8'h00;
        adj_c    = bin_c_reg;
        if (op_reg == OP_ADC) begin
            if ((bin_y_reg[3:0] > 4'd9) || hc_reg) begin
                adj_corr = adj_corr + 8'h06;
            end
            if (bin_c_reg || (bin_y_reg > 8'h99)) begin
                adj_corr = adj_corr + 8'h60;
            end
            adj_c = bin_c_reg || (bin_y_reg > 8'h99);
        end else begin
            // Subtract 6 / 0x60 expressed as modular additions
            if (!hc_reg) begin
                adj_corr = adj_corr + 8'hFA;
            end
            if (!bin_c_reg) begin
                adj_corr = adj_corr + 8'hA0;
            end
        end
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (req_valid) begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
`ifdef DECIMAL_EN
                if (dec_run) begin
                    state_next = S_ADJ;
                end else begin
                    state_next = S_RESP;
                end
`else
                state_next = S_RESP;
`endif
            end
`ifdef DECIMAL_EN
            S_ADJ: begin
                state_next = S_RESP;
            end
`endif
            S_RESP: begin
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ALU drive: idle values everywhere except the active passes
    always_comb begin
        alu_ctrl  = CTRL_SUM;
        alu_AI    = 8'h00;
        alu_BI    = 8'h00;
        alu_carry = 1'b0;
        if (state_reg == S_EXEC) begin
            case (op_reg)
                OP_ADC: begin
                    alu_AI = a_reg; alu_BI = b_reg; alu_carry = p_reg[0];
                end
                OP_SBC: begin
                    alu_AI = a_reg; alu_BI = ~b_reg; alu_carry = p_reg[0];
                end
                OP_CMP: begin
                    alu_AI = a_reg; alu_BI = ~b_reg; alu_carry = 1'b1;
                end
                OP_AND, OP_BIT: begin
                    alu_ctrl = CTRL_AND; alu_AI = a_reg; alu_BI = b_reg;
                end
                OP_ORA: begin
                    alu_ctrl = CTRL_OR; alu_AI = a_reg; alu_BI = b_reg;
                end
                OP_EOR: begin
                    alu_ctrl = CTRL_XOR; alu_AI = a_reg; alu_BI = b_reg;
                end
                OP_ASL: begin
                    alu_AI = a_reg; alu_BI = a_reg;
                end
                OP_ROL: begin
                    alu_AI = a_reg; alu_BI = a_reg; alu_carry = p_reg[0];
                end
                OP_LSR: begin
                    alu_ctrl = CTRL_SR; alu_AI = a_reg;
                end
                OP_ROR: begin
                    alu_ctrl = CTRL_SR; alu_AI = a_reg; alu_carry = p_reg[0];
                end
                OP_INC: begin
                    alu_AI = a_reg; alu_BI = 8'h00; alu_carry = 1'b1;
                end
                OP_DEC: begin
                    alu_AI = a_reg; alu_BI = 8'hFF;
                end
                default: begin
                    // Illegal op: ALU left at idle values
                end
            endcase
        end
`ifdef DECIMAL_EN
        else if (state_reg == S_ADJ) begin
            alu_AI = bin_y_reg;
            alu_BI = adj_corr;
        end
`endif
    end

    assign alu_DAA = 1'b0;

    // Result and flag derivation for the EXEC pass
    always_comb begin
        exec_y  = alu_Y;
        exec_p  = p_reg;
        exec_wr = 1'b1;
        case (op_reg)
            OP_ADC, OP_SBC: begin
                exec_p[7] = alu_Y[7];
                exec_p[6] = (alu_AI[7] == alu_BI[7]) && (alu_Y[7] != alu_AI[7]);
                exec_p[1] = (alu_Y == 8'h00);
                exec_p[0] = alu_flags[0];
            end
            OP_CMP: begin
                exec_p[7] = alu_Y[7];
                exec_p[1] = (alu_Y == 8'h00);
                exec_p[0] = alu_flags[0];
                exec_wr   = 1'b0;
            end
            OP_ASL, OP_ROL, OP_LSR, OP_ROR: begin
                exec_p[7] = alu_Y[7];
                exec_p[1] = (alu_Y == 8'h00);
                exec_p[0] = alu_flags[0];
            end
            OP_AND, OP_ORA, OP_EOR, OP_INC, OP_DEC: begin
                exec_p[7] = alu_Y[7];
                exec_p[1] = (alu_Y == 8'h00);
            end
            OP_BIT: begin
                exec_p[7] = b_reg[7];
                exec_p[6] = b_reg[6];
                exec_p[1] = (alu_Y == 8'h00);
                exec_wr   = 1'b0;
            end
            default: begin
                exec_y  = a_reg;
                exec_wr = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg     <= 4'd0;
            a_reg      <= 8'h00;
            b_reg      <= 8'h00;
            p_reg      <= 8'h00;
            rsp_y_reg  <= 8'h00;
            rsp_p_reg  <= 8'h00;
            rsp_wr_reg <= 1'b0;
`ifdef DECIMAL_EN
            bin_y_reg  <= 8'h00;
            bin_c_reg  <= 1'b0;
            hc_reg     <= 1'b0;
`endif
        end else begin
            if ((state_reg == S_IDLE) && req_valid) begin
                op_reg <= req_op;
                a_reg  <= req_a;
                b_reg  <= req_b;
                p_reg  <= req_p;
            end
            if (state_reg == S_EXEC) begin
                rsp_y_reg  <= exec_y;
                rsp_p_reg  <= exec_p;
                rsp_wr_reg <= exec_wr;
`ifdef DECIMAL_EN
                bin_y_reg  <= alu_Y;
                bin_c_reg  <= alu_flags[0];
                hc_reg     <= low_sum[4];
`endif
            end
`ifdef DECIMAL_EN
            // N/Z from the adjusted byte, V kept from the binary pass
            if (state_reg == S_ADJ) begin
                rsp_y_reg    <= alu_Y;
                rsp_p_reg[7] <= alu_Y[7];
                rsp_p_reg[1] <= (alu_Y == 8'h00);
                rsp_p_reg[0] <= adj_c;
            end
`endif
        end
    end

    assign req_ready = (state_reg == S_IDLE);
    assign rsp_valid = (state_reg == S_RESP);
    assign rsp_y     = rsp_y_reg;
    assign rsp_p     = rsp_p_reg;
    assign rsp_wr    = rsp_wr_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
`timescale 1ns/1ps
module tb_alu_sequencer;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_op;
    logic [7:0] req_a, req_b, req_p;
    logic [2:0] alu_ctrl;
    logic [7:0] alu_AI, alu_BI;
    logic       alu_carry, alu_DAA;
    logic [7:0] alu_Y, alu_flags;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_y, rsp_p;
    logic       rsp_wr;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] p;
        logic       wr;
    } exp_t;

    exp_t sb[$];

    alu_sequencer dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_p(req_p),
        .alu_ctrl(alu_ctrl), .alu_AI(alu_AI), .alu_BI(alu_BI),
        .alu_carry(alu_carry), .alu_DAA(alu_DAA),
        .alu_Y(alu_Y), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_p(rsp_p), .rsp_wr(rsp_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 6502 ALU datapath
    always_comb begin
        logic [8:0] s;
        s = 9'd0;
        alu_Y = 8'h00;
        alu_flags = 8'h00;
        case (alu_ctrl)
            3'd0: begin
                s = {1'b0, alu_AI} + {1'b0, alu_BI} + {8'd0, alu_carry};
                alu_Y = s[7:0];
                alu_flags[0] = s[8];
            end
            3'd1: alu_Y = alu_AI | alu_BI;
            3'd2: alu_Y = alu_AI ^ alu_BI;
            3'd3: alu_Y = alu_AI & alu_BI;
            3'd4: begin
                alu_Y = {alu_carry, alu_AI[7:1]};
                alu_flags[0] = alu_AI[0];
            end
            default: alu_Y = 8'h00;
        endcase
    end

    // Reference: 6502 instruction semantics
    function automatic exp_t ref_model(input logic [3:0] op, input logic [7:0] a,
                                       input logic [7:0] b, input logic [7:0] p);
        exp_t e;
        logic [8:0] s;
        logic [7:0] y;
        int da, db, t;
        e.p = p;
        e.wr = 1'b1;
        y = 8'h00;
        case (op)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b} + {8'd0, p[0]};
                y = s[7:0];
                e.p[0] = s[8];
                e.p[6] = (a[7] == b[7]) && (y[7] != a[7]);
            end
            4'd1: begin
                s = {1'b0, a} - {1'b0, b} - {8'd0, !p[0]};
                y = s[7:0];
                e.p[0] = !s[8];
                e.p[6] = (a[7] != b[7]) && (y[7] != a[7]);
            end
            4'd2: y = a & b;
            4'd3: y = a | b;
            4'd4: y = a ^ b;
            4'd5: begin y = {a[6:0], 1'b0}; e.p[0] = a[7]; end
            4'd6: begin y = {1'b0, a[7:1]}; e.p[0] = a[0]; end
            4'd7: begin y = {a[6:0], p[0]}; e.p[0] = a[7]; end
            4'd8: begin y = {p[0], a[7:1]}; e.p[0] = a[0]; end
            4'd9: begin y = a - b; e.p[0] = (a >= b); e.wr = 1'b0; end
            4'd10: y = a + 8'd1;
            4'd11: y = a - 8'd1;
            4'd12: begin
                e.y = a & b;
                e.p[7] = b[7];
                e.p[6] = b[6];
                e.p[1] = ((a & b) == 8'h00);
                e.wr = 1'b0;
                return e;
            end
            default: begin
                e.y = a;
                e.wr = 1'b0;
                return e;
            end
        endcase
`ifdef DECIMAL_EN
        // BCD arithmetic on decimal digits (valid for BCD operands)
        if (p[3] && (op == 4'd0 || op == 4'd1)) begin
            da = a[7:4] * 10 + a[3:0];
            db = b[7:4] * 10 + b[3:0];
            if (op == 4'd0) begin
                t = da + db + int'(p[0]);
                e.p[0] = (t >= 100);
                t = t % 100;
            end else begin
                t = da - db - (1 - int'(p[0]));
                e.p[0] = (t >= 0);
                if (t < 0) t = t + 100;
            end
            y = {4'(t / 10), 4'(t % 10)};
        end
`endif
        e.y = y;
        e.p[7] = y[7];
        e.p[1] = (y == 8'h00);
        return e;
    endfunction

    function automatic int exp_latency(input logic [3:0] op, input logic [7:0] p);
`ifdef DECIMAL_EN
        if (p[3] && (op == 4'd0 || op == 4'd1)) return 2;
`endif
        return 1;
    endfunction

    // One transaction: drive, push expectation, wait response, pop and compare.
    // Latency counts rising edges after the accept edge until rsp_valid is seen.
    task automatic run_op(input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] p);
        exp_t e;
        int lat;
        int want_lat;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL req_ready_idle: got %b want 1", req_ready);
        end
        req_op = op; req_a = a; req_b = b; req_p = p; req_valid = 1'b1;
        sb.push_back(ref_model(op, a, b, p));
        want_lat = exp_latency(op, p);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        vectors++;
        if (lat != want_lat) begin
            miscompares++;
            $display("FAIL latency op=%0d: got %0d want %0d", op, lat, want_lat);
        end
        e = sb.pop_front();
        vectors++;
        if (rsp_y !== e.y) begin
            miscompares++;
            $display("FAIL rsp_y op=%0d a=%h b=%h p=%h: got %h want %h", op, a, b, p, rsp_y, e.y);
        end
        vectors++;
        if (rsp_p !== e.p) begin
            miscompares++;
            $display("FAIL rsp_p op=%0d a=%h b=%h p=%h: got %h want %h", op, a, b, p, rsp_p, e.p);
        end
        vectors++;
        if (rsp_wr !== e.wr) begin
            miscompares++;
            $display("FAIL rsp_wr op=%0d: got %b want %b", op, rsp_wr, e.wr);
        end
        $display("op=%0d a=%h b=%h p=%h -> y=%h p=%h wr=%b lat=%0d",
                 op, a, b, p, rsp_y, rsp_p, rsp_wr, lat);
        @(posedge clk);
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL post_handshake: got valid=%b ready=%b want valid=0 ready=1",
                     rsp_valid, req_ready);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        logic [40:0] got;
        got = {req_ready, rsp_valid, rsp_y, rsp_p, rsp_wr, alu_ctrl, alu_AI, alu_BI, alu_carry, alu_DAA};
        vectors++;
        if (got !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL %s: got rdy=%b vld=%b y=%h p=%h wr=%b ctrl=%0d ai=%h bi=%h c=%b daa=%b want 1 0 00 00 0 0 00 00 0 0",
                     tag, req_ready, rsp_valid, rsp_y, rsp_p, rsp_wr, alu_ctrl, alu_AI, alu_BI, alu_carry, alu_DAA);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_op = 4'd0; req_a = 8'h00; req_b = 8'h00; req_p = 8'h00;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("reset_values");
        rst = 1'b0;
        @(posedge clk);
        #1 check_idle_outputs("after_reset");
    endtask

    task automatic test_plan_vectors();
        run_op(4'd0, 8'h50, 8'h50, 8'h00);  // ADC -> A0, N V
        run_op(4'd1, 8'h00, 8'h01, 8'h01);  // SBC -> FF, C=0 N=1
        run_op(4'd9, 8'h10, 8'h10, 8'h00);  // CMP equal -> Z C
        run_op(4'd8, 8'h01, 8'h00, 8'h01);  // ROR -> 80, C N
        run_op(4'd6, 8'h01, 8'h00, 8'h00);  // LSR -> 00, Z C
        run_op(4'd12, 8'h0F, 8'hC0, 8'h00); // BIT -> Z N V
    endtask

    task automatic test_all_ops();
        for (int op = 0; op < 16; op++) begin
            for (int k = 0; k < 3; k++) begin
                run_op(4'(op), 8'($urandom), 8'($urandom), 8'($urandom) & 8'hF7);
            end
        end
        // Boundary operands
        run_op(4'd10, 8'hFF, 8'h00, 8'h00); // INC wrap -> Z
        run_op(4'd11, 8'h00, 8'h00, 8'h02); // DEC wrap -> N
        run_op(4'd0, 8'hFF, 8'h01, 8'h00);  // ADC carry out, Z
        run_op(4'd0, 8'h80, 8'h80, 8'h00);  // ADC negative overflow
        run_op(4'd7, 8'h80, 8'h00, 8'h00);  // ROL -> 00, C
        run_op(4'd5, 8'h40, 8'h00, 8'h01);  // ASL -> 80, C cleared
        run_op(4'd9, 8'h01, 8'h02, 8'h00);  // CMP less -> C=0
    endtask

    task automatic test_decimal();
`ifdef DECIMAL_EN
        run_op(4'd0, 8'h19, 8'h28, 8'h08);  // -> 47 C=0
        run_op(4'd0, 8'h99, 8'h01, 8'h08);  // -> 00 C=1 Z=1
        run_op(4'd1, 8'h50, 8'h01, 8'h09);  // -> 49 C=1
        for (int k = 0; k < 8; k++) begin
            run_op(4'($urandom_range(0, 1)),
                   {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))},
                   {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))},
                   8'h08 | 8'($urandom_range(0, 1)));
        end
`else
        // D flag has no effect: binary result and single-pass latency
        run_op(4'd0, 8'h19, 8'h28, 8'h08);
        run_op(4'd1, 8'h50, 8'h01, 8'h09);
`endif
    endtask

    task automatic test_hold();
        exp_t e;
        int lat;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_op = 4'd0; req_a = 8'h12; req_b = 8'h34; req_p = 8'h00; req_valid = 1'b1;
        sb.push_back(ref_model(4'd0, 8'h12, 8'h34, 8'h00));
        @(posedge clk);
        // A second request stays pending while the first is outstanding
        #1 req_op = 4'd10; req_a = 8'h7F; req_b = 8'h00; req_p = 8'h00;
        sb.push_back(ref_model(4'd10, 8'h7F, 8'h00, 8'h00));
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_y !== e.y ||
                rsp_p !== e.p || rsp_wr !== e.wr) begin
                miscompares++;
                $display("FAIL hold_stable cycle %0d: got v=%b r=%b y=%h p=%h wr=%b want v=1 r=0 y=%h p=%h wr=%b",
                         i, rsp_valid, req_ready, rsp_y, rsp_p, rsp_wr, e.y, e.p, e.wr);
            end
        end
        $display("hold: op=0 a=12 b=34 -> y=%h p=%h wr=%b held 5 cycles", rsp_y, rsp_p, rsp_wr);
        void'(sb.pop_front());
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_release_idle: got r=%b v=%b want r=1 v=0", req_ready, rsp_valid);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL pending_accept: got req_ready=%b want 0", req_ready);
        end
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb.pop_front();
        vectors++;
        if (lat != 1 || rsp_y !== e.y || rsp_p !== e.p || rsp_wr !== e.wr) begin
            miscompares++;
            $display("FAIL pending_rsp: got lat=%0d y=%h p=%h wr=%b want lat=1 y=%h p=%h wr=%b",
                     lat, rsp_y, rsp_p, rsp_wr, e.y, e.p, e.wr);
        end
        $display("pending: op=10 a=7F -> y=%h p=%h wr=%b lat=%0d", rsp_y, rsp_p, rsp_wr, lat);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_exec();
        int seen;
        @(negedge clk);
        req_op = 4'd0; req_a = 8'h11; req_b = 8'h22; req_p = 8'h01; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 check_idle_outputs("reset_in_exec");
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (rsp_valid === 1'b1) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL aborted_rsp: got %0d response cycles want 0", seen);
        end
        $display("reset in EXEC: aborted ADC 11+22, response cycles=%0d", seen);
        run_op(4'd4, 8'hAA, 8'h55, 8'h00);  // recovery
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            run_op(4'($urandom_range(0, 12)), 8'($urandom), 8'($urandom), 8'($urandom) & 8'hF7);
        end
    endtask

    initial begin
        fork
            begin
                #200000;
                $display("FAIL timeout: got no completion want $finish");
                $fatal(1, "timeout");
            end
        join_none
        test_reset();
        test_plan_vectors();
        test_all_ops();
        test_decimal();
        test_hold();
        test_reset_exec();
        test_back_to_back();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: got %0d entries want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
